// File: rtl/line_xfer_pkg.sv
// Shared types and helpers for the line transfer engine.
package line_xfer_pkg;

  localparam int unsigned WORDS = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_WB   = 1'b1;

  // Read-return token: which cache word the data in flight belongs to.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } ret_tok_t;

  // Bank is the word offset inside the line (byte address bits [2:1]).
  function automatic logic [IDX_W-1:0] bank_of(input logic [2:0] addr_lo);
    return addr_lo[2:1];
  endfunction

endpackage

// File: rtl/line_xfer_ret_pipe.sv
// Fixed-latency shift register of read-return tokens with an empty flag.
module line_xfer_ret_pipe
  import line_xfer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [IDX_W-1:0] push_idx,
  output logic             pop_valid,
  output logic [IDX_W-1:0] pop_idx,
  output logic             empty
);

  ret_tok_t stage_q [DEPTH];
  ret_tok_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = '{valid: push_valid, idx: push_idx};
    for (int i = 1; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= stage_d[i];
    end
  end

  assign pop_valid = stage_q[DEPTH-1].valid;
  assign pop_idx   = stage_q[DEPTH-1].idx;

  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (stage_q[i].valid) empty = 1'b0;
    end
  end

endmodule

// File: rtl/line_xfer_engine.sv
// Moves one 4-word cache line between the cache data array and banked memory.
// Optional LINE_XFER_CRIT_WORD_FIRST_EN: fills start at crit_word and wrap.
module line_xfer_engine
  import line_xfer_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-4:0] line_addr,
  input  logic [1:0]        crit_word,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic [1:0]        word_idx,
  output logic              cache_we,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              xfer_busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [3:0]        mem_busy,
  input  logic              mem_stall,
  input  logic              mem_err
);

  localparam int unsigned LINE_W = ADDR_W - 3;

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0]  off_c;
  logic [IDX_W-1:0]  start_word_c;
  logic [ADDR_W-1:0] issue_addr_c;
  logic              can_issue_c;
  logic              push_c;
  logic              pop_valid_c;
  logic [IDX_W-1:0]  pop_idx_c;
  logic              pipe_empty_c;

  // Word offset wraps modulo the line length through the 2-bit add.
  assign off_c        = base_q + cnt_q;
  assign issue_addr_c = {line_q, off_c, 1'b0};
  assign can_issue_c  = !mem_stall && !mem_busy[bank_of(issue_addr_c[2:0])];

`ifdef LINE_XFER_CRIT_WORD_FIRST_EN
  assign start_word_c = (op == OP_FILL) ? crit_word : '0;
`else
  logic unused_crit_c;
  assign unused_crit_c = ^crit_word;
  assign start_word_c  = '0;
`endif

  assign xfer_busy = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    line_d      = line_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    err_d       = err_q | (mem_err && (state_q != ST_IDLE));
    push_c      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    word_idx    = '0;
    cache_we    = 1'b0;
    cache_wdata = '0;
    done        = 1'b0;
    err         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          line_d  = line_addr;
          base_d  = start_word_c;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_addr = issue_addr_c;
        if (op_q == OP_WB) begin
          word_idx  = off_c;
          mem_wdata = cache_rdata;
        end
        if (can_issue_c) begin
          mem_rd = (op_q == OP_FILL);
          mem_wr = (op_q == OP_WB);
          push_c = (op_q == OP_FILL);
          cnt_d  = IDX_W'(cnt_q + 1'b1);
          if (cnt_q == IDX_W'(WORDS - 1)) begin
            state_d = (op_q == OP_FILL) ? ST_DRAIN : ST_FIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_empty_c) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Read returns are written into the cache as they arrive, in any state.
    if (pop_valid_c) begin
      cache_we    = 1'b1;
      word_idx    = pop_idx_c;
      cache_wdata = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_FILL;
      line_q  <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      line_q  <= line_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  line_xfer_ret_pipe #(
    .DEPTH(RD_LAT)
  ) u_ret_pipe (
    .clk       (clk),
    .rst       (rst),
    .push_valid(push_c),
    .push_idx  (off_c),
    .pop_valid (pop_valid_c),
    .pop_idx   (pop_idx_c),
    .empty     (pipe_empty_c)
  );

endmodule

// File: tb/tb_line_xfer_engine.sv
// Scoreboard bench for line_xfer_engine: randomized and directed line transfers
// checked against a transaction-level model of word order, data and latency.
module tb_line_xfer_engine;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_LAT = 2;
`ifdef LINE_XFER_CRIT_WORD_FIRST_EN
  localparam bit CRIT_EN = 1'b1;
`else
  localparam bit CRIT_EN = 1'b0;
`endif

  typedef struct { logic [15:0] addr; logic wr; logic [15:0] wdata; logic [1:0] idx; } iss_t;
  typedef struct { logic [1:0] idx; logic [15:0] data; } cw_t;
  typedef struct { logic fill; int exp_cyc; } dn_t;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [12:0] line_addr;
  logic [1:0]  crit_word;
  logic [15:0] cache_rdata;
  logic [1:0]  word_idx;
  logic        cache_we;
  logic [15:0] cache_wdata;
  logic        xfer_busy, done, err;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic [3:0]  mem_busy;
  logic        mem_stall, mem_err;

  line_xfer_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .line_addr(line_addr),
    .crit_word(crit_word), .cache_rdata(cache_rdata), .word_idx(word_idx),
    .cache_we(cache_we), .cache_wdata(cache_wdata), .xfer_busy(xfer_busy),
    .done(done), .err(err), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .mem_stall(mem_stall), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   done_cnt = 0;
  int   last_iss = 0;
  bit   exp_busy = 1'b0;
  bit   err_seen = 1'b0;
  bit   quiet = 1'b0;
  logic [15:0] salt = 16'h0;
  logic [15:0] wb_line [4];
  bit          rd_v [4];
  logic [15:0] rd_a [4];

  iss_t iss_q [$];
  cw_t  cw_q  [$];
  dn_t  done_q[$];

  // Cache data array seen by writebacks.
  assign cache_rdata = wb_line[word_idx];

  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic [15:0] s);
    return 16'(a * 16'h9E37) ^ s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Memory read data appears RD_LAT cycles after the mem_rd cycle.
  always @(posedge clk) begin
    #1;
    if (rd_v[(cyc - 2) & 3]) mem_rdata = mem_word(rd_a[(cyc - 2) & 3], salt);
    else                     mem_rdata = 16'hDEAD;
  end

  iss_t        mon_e;
  cw_t         mon_c;
  dn_t         mon_d;
  logic [15:0] nxt;
  bit          want;

  always @(negedge clk) begin
    rd_v[cyc & 3] = mem_rd;
    rd_a[cyc & 3] = mem_addr;
    if (quiet) begin
      chk("quiet_after_reset", 32'({cache_we, done, mem_rd, mem_wr, xfer_busy}), 32'd0);
    end else if (rst) begin
      chk("xfer_busy", 32'(xfer_busy), 32'(exp_busy));
      want = 1'b0;
      if (exp_busy && iss_q.size() != 0) begin
        nxt  = iss_q[0].addr;
        want = !mem_stall && !mem_busy[nxt[2:1]];
      end
      if (want || mem_rd || mem_wr) begin
        chk("issue_fires", 32'(mem_rd | mem_wr), 32'(want));
        if ((mem_rd || mem_wr) && iss_q.size() != 0) begin
          mon_e = iss_q.pop_front();
          chk("issue_addr", 32'(mem_addr), 32'(mon_e.addr));
          chk("issue_dir", 32'({mem_wr, mem_rd}), mon_e.wr ? 32'd2 : 32'd1);
          if (mon_e.wr) begin
            chk("wb_data", 32'(mem_wdata), 32'(mon_e.wdata));
            chk("wb_idx", 32'(word_idx), 32'(mon_e.idx));
          end
          last_iss = cyc;
        end
      end
      if (cache_we) begin
        if (cw_q.size() == 0) chk("cache_we_expected", 32'(cache_we), 32'd0);
        else begin
          mon_c = cw_q.pop_front();
          chk("fill_idx", 32'(word_idx), 32'(mon_c.idx));
          chk("fill_data", 32'(cache_wdata), 32'(mon_c.data));
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_expected", 32'(done), 32'd0);
        else begin
          mon_d = done_q.pop_front();
          chk("done_err", 32'(err), 32'(err_seen));
          chk("done_latency", 32'(cyc - last_iss), mon_d.fill ? 32'(RD_LAT + 2) : 32'd1);
          if (mon_d.exp_cyc != 0) chk("done_cycle", 32'(cyc), 32'(mon_d.exp_cyc));
          chk("line_complete", 32'(iss_q.size() + cw_q.size()), 32'd0);
        end
        exp_busy = 1'b0;
        err_seen = 1'b0;
        done_cnt++;
      end else if (exp_busy && mem_err) begin
        err_seen = 1'b1;
      end
    end
  end

  task automatic flush();
    iss_q.delete();
    cw_q.delete();
    done_q.delete();
    exp_busy = 1'b0;
  endtask

  // mode: 0 clean, 1 bank1 busy 3 cycles, 2 mem_err on word 2, 3 random, 4 reset in DRAIN
  task automatic run_txn(input logic t_op, input logic [12:0] t_line, input logic [1:0] t_crit,
                         input int mode);
    int s, d0, base, rel;
    logic [1:0] w;
    logic [15:0] a;
    iss_t e;
    cw_t c;
    dn_t dn;
    bit got;
    for (int k = 0; k < 4; k++) wb_line[k] = 16'($urandom);
    salt = 16'($urandom);
    base = (CRIT_EN && t_op == 1'b0) ? int'(t_crit) : 0;
    for (int k = 0; k < 4; k++) begin
      w = 2'((base + k) % 4);
      a = {t_line, w, 1'b0};
      e.addr = a; e.wr = t_op; e.wdata = wb_line[w]; e.idx = w;
      iss_q.push_back(e);
      if (!t_op) begin
        c.idx = w; c.data = mem_word(a, salt);
        cw_q.push_back(c);
      end
    end
    s = cyc;
    dn.fill = !t_op;
    case (mode)
      0:       dn.exp_cyc = t_op ? s + 5 : s + 4 + RD_LAT + 2;
      1:       dn.exp_cyc = s + 4 + RD_LAT + 2 + 3;
      2:       dn.exp_cyc = s + 5;
      default: dn.exp_cyc = 0;
    endcase
    done_q.push_back(dn);
    start = 1'b1; op = t_op; line_addr = t_line; crit_word = t_crit;
    err_seen = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    exp_busy = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 300; n++) begin
      rel = cyc - s;
      mem_busy = '0; mem_stall = 1'b0; mem_err = 1'b0;
      case (mode)
        1: if (rel >= 2 && rel <= 4) mem_busy = 4'b0010;
        2: mem_err = (rel == 3);
        3: begin
          mem_busy  = 4'($urandom & $urandom);
          mem_stall = ($urandom_range(0, 4) == 0);
          mem_err   = ($urandom_range(0, 15) == 0);
          start     = (rel == 2);
          if (rel == 2) begin op = ~t_op; line_addr = 13'($urandom); end
        end
        4: begin
          if (rel == 5) rst = 1'b0;
          else if (rel == 6) begin rst = 1'b1; flush(); quiet = 1'b1; got = 1'b1; end
        end
        default: ;
      endcase
      if (got) break;
      @(posedge clk); #1;
      if (done_cnt != d0) begin got = 1'b1; break; end
    end
    start = 1'b0; mem_busy = '0; mem_stall = 1'b0; mem_err = 1'b0;
    if (mode == 4) begin
      repeat (5) @(posedge clk);
      #1 quiet = 1'b0;
    end else if (!got) begin
      chk("done_timeout", 32'(done_cnt), 32'(d0 + 1));
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      flush();
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 1'b0; line_addr = '0; crit_word = '0;
    mem_busy = '0; mem_stall = 1'b0; mem_err = 1'b0;
    for (int k = 0; k < 4; k++) wb_line[k] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_ctrl", 32'({done, err, cache_we, mem_rd, mem_wr, xfer_busy}), 32'd0);
    chk("reset_addr", 32'({mem_addr, word_idx}), 32'd0);
    @(posedge clk); #1;
    run_txn(1'b0, 13'h0123, 2'd0, 0);
    run_txn(1'b1, 13'($urandom), 2'd0, 0);
    run_txn(1'b0, 13'($urandom), 2'd0, 1);
    run_txn(1'b1, 13'($urandom), 2'd0, 2);
    run_txn(1'b1, 13'($urandom), 2'd0, 0);
    run_txn(1'b0, 13'($urandom), 2'd0, 4);
    run_txn(1'b0, 13'($urandom), 2'd0, 0);
    run_txn(1'b0, 13'($urandom), 2'd2, 0);
    run_txn(1'b1, 13'($urandom), 2'd3, 0);
    repeat (40) run_txn(1'($urandom), 13'($urandom), 2'($urandom), 3);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/line_xfer_engine.md
Name: line_xfer_engine

Overview:
- Memory-side sequencer sitting directly downstream of the direct-mapped cache controller, between it and the four-banked main memory.
- On a controller request it moves one 4-word cache line: either a fill (memory to cache) or a writeback (cache to memory).
- It generates per-word addresses, honours per-bank busy, and pipelines read returns into the cache data array.
- The controller then only waits for a single done pulse instead of counting MW/MR cycles itself.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- WORDS, 4, words per line; fixed at 4 because bank = word offset.
- RD_LAT, 2, cycles from mem_rd issue to valid mem_rdata.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request pulse from the cache controller.
- op  in  1  0 = fill, 1 = writeback; sampled with start.
- line_addr  in  ADDR_W-3  line address ({tag,index}); sampled with start.
- crit_word  in  2  requested word offset; sampled with start; used only when the optional feature is compiled in.
- cache_rdata  in  DATA_W  cache word selected by word_idx; combinational source for writebacks.
- word_idx  out  2  cache word being read (writeback) or written (fill).
- cache_we  out  1  write strobe into the cache data array (fill only).
- cache_wdata  out  DATA_W  fill data.
- xfer_busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 if mem_err was seen during the transfer.
- mem_addr  out  ADDR_W  word address = {line_addr, k, 1'b0}.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read return data.
- mem_busy  in  4  per-bank busy; bank = mem_addr[2:1].
- mem_stall  in  1  global memory stall.
- mem_err  in  1  memory error.

Behaviour:
- Reset (rst==0 at clk): state=IDLE, return pipe cleared, err latch cleared.
  - All outputs 0 next cycle.
  - Reset mid-transfer abandons it with no done pulse.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - start=1 latches op, line_addr and start word, clears the err latch, and moves to ISSUE.
  - start while not IDLE is ignored.
- ISSUE:
  - Issues word k (issue counter 0..3, offset = start word + counter, mod 4).
  - Issue fires when !mem_stall && !mem_busy[bank(k)]; otherwise the counter holds and mem_rd/mem_wr stay low.
  - Fill: mem_rd=1, and a {valid,k} token is pushed into an RD_LAT-deep return pipe.
  - Writeback: mem_wr=1, word_idx=k, mem_wdata=cache_rdata.
  - After the 4th issue:
    - fill goes to DRAIN;
    - writeback goes to FIN.
- DRAIN: waits until the return pipe is empty, then goes to FIN.
- Return pipe (any state):
  - A token reaching the output asserts cache_we=1, word_idx=token k, cache_wdata=mem_rdata in that same cycle.
  - Returns are never stalled.
- FIN: done=1 for one cycle, err=latched err, then IDLE.
- err latch sets on any cycle with mem_err=1 while xfer_busy. The transfer still runs to completion (no abort).
- Minimum latency with no stalls:
  - fill: 4 issue cycles + RD_LAT + 1 (done 7 cycles after entering ISSUE);
  - writeback: 4 + 1.
- Simultaneous events:
  - The last return and DRAIN exit in the same cycle is legal; FIN follows.
  - mem_stall during DRAIN has no effect.
- Word order (default): 0,1,2,3, with crit_word ignored.

Optional Feature:
- Macro: LINE_XFER_CRIT_WORD_FIRST_EN.
- Defined: fills start at crit_word and wrap (e.g. 2,3,0,1), so the requested word is written to the cache first. Writebacks always use 0..3.
- Undefined: the crit_word port exists but is ignored; all transfers use 0..3.

Decomposition:
- line_xfer_pkg holds:
  - state encoding constants (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2, FIN=2'd3);
  - OP_FILL/OP_WB;
  - bank-select function addr[2:1].
- Sub-module line_xfer_ret_pipe: a parameterised RD_LAT-deep shift register of {valid, idx[1:0]} with an empty flag.

Test Plan:
- Fill, line_addr=0x0123, mem_busy=0, no stall:
  - issues at mem_addr 0x0918, 0x091A, 0x091C, 0x091E on consecutive cycles;
  - cache_we for idx 0..3 at issue+2;
  - done 7 cycles after ISSUE entry, err=0.
- Writeback, cache words A0,A1,A2,A3:
  - mem_wr on 4 cycles with mem_wdata A0..A3 and word_idx 0..3;
  - done on the 5th cycle.
- Fill with mem_busy[1]=1 for 3 cycles:
  - word 1 issue delayed 3 cycles and words 2,3 follow in order;
  - all 4 data words are captured correctly and done is delayed by 3.
- mem_err pulse during the word-2 issue of a writeback: all 4 writes still occur; done=1 with err=1; the next transfer shows err=0.
- rst=0 asserted while in DRAIN with 1 token in flight: no cache_we and no done afterward; state IDLE; a new start works normally.
- With LINE_XFER_CRIT_WORD_FIRST_EN defined, fill with crit_word=2: addresses issued in word order 2,3,0,1; first cache_we has word_idx=2.
